// File: rtl/chaz_bus_pkg.sv
// Shared bus definitions for the SoC memory port: region codes, one-hot
// selects, arbiter FSM/owner encodings and the requester bundle.
package chaz_bus_pkg;

   typedef enum logic [1:0] {
      REG_RAM  = 2'b00,
      REG_MMIO = 2'b01,
      REG_ROM  = 2'b10,
      REG_NONE = 2'b11
   } region_e;

   localparam logic [2:0] SEL_RAM  = 3'b001;
   localparam logic [2:0] SEL_MMIO = 3'b010;
   localparam logic [2:0] SEL_ROM  = 3'b100;
   localparam logic [2:0] SEL_NONE = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   typedef enum logic {
      OWN_DBG = 1'b0,
      OWN_CPU = 1'b1
   } owner_e;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] wdata;
      logic [3:0]  wren;
   } bus_req_t;

   function automatic logic [2:0] region_sel(input region_e r);
      logic [2:0] s;
      case (r)
         REG_RAM:  s = SEL_RAM;
         REG_MMIO: s = SEL_MMIO;
         REG_ROM:  s = SEL_ROM;
         default:  s = SEL_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Byte address to memory region decode; only adr[17:16] matter, the rest
// of the address is deliberately ignored.
module mem_region_decode
   import chaz_bus_pkg::*;
(
   input  logic [31:0] adr,
   output region_e     region,
   output logic [2:0]  sel,
   output logic        unmapped
);

   logic unused_adr;
   assign unused_adr = ^{adr[31:18], adr[15:0]};

   always_comb begin
      region   = region_e'(adr[17:16]);
      sel      = region_sel(region);
      unmapped = (region == REG_NONE);
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (debug loader, CPU) arbiter for the single memory port with one
// outstanding transaction, bus timeout and a debug burst limit.
module mem_bus_arbiter
   import chaz_bus_pkg::*;
#(
   parameter int ADR_W         = 18,
   parameter int TIMEOUT       = 16,
   parameter int MAX_DBG_BURST = 8
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             dbg_req,
   input  logic [31:0]      dbg_adr,
   input  logic [31:0]      dbg_wdata,
   input  logic [3:0]       dbg_wren,
   output logic             dbg_ack,
   output logic [31:0]      dbg_rdata,
   output logic             dbg_err,
   input  logic             cpu_req,
   input  logic [31:0]      cpu_adr,
   input  logic [31:0]      cpu_wdata,
   input  logic [3:0]       cpu_wren,
   output logic             cpu_ack,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_err,
   output logic             mem_en,
   output logic [ADR_W-1:0] mem_adr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wren,
   output logic [2:0]       mem_sel,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_rdy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = (MAX_DBG_BURST < 1) ? 1 : $clog2(MAX_DBG_BURST + 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DBG_BURST);

   state_e        state;
   owner_e        owner;
   logic [SW-1:0] streak;
   logic [TW-1:0] tmo_cnt;

   bus_req_t dbg_bus, cpu_bus, gnt_bus;
   logic     cpu_hold, grant_dbg, grant_cpu, grant_any;
   region_e  unused_region;
   logic [2:0] dec_sel;
   logic     dec_unmapped;

   logic        fin, fin_dbg, fin_err;
   logic [31:0] fin_rdata;

   assign dbg_bus = '{adr: dbg_adr, wdata: dbg_wdata, wren: dbg_wren};
   assign cpu_bus = '{adr: cpu_adr, wdata: cpu_wdata, wren: cpu_wren};

   // Debug wins unless it has used up its burst while the CPU waits.
   assign cpu_hold  = cpu_req && (MAX_DBG_BURST != 0) && (streak == STREAK_MAX);
   assign grant_dbg = dbg_req && !cpu_hold;
   assign grant_cpu = !grant_dbg && cpu_req;
   assign grant_any = grant_dbg || grant_cpu;
   assign gnt_bus   = grant_dbg ? dbg_bus : cpu_bus;

   mem_region_decode u_dec (
      .adr      (gnt_bus.adr),
      .region   (unused_region),
      .sel      (dec_sel),
      .unmapped (dec_unmapped)
   );

   // Completion of the current transaction; feeds the registered responses.
   always_comb begin
      fin       = 1'b0;
      fin_dbg   = (owner == OWN_DBG);
      fin_rdata = '0;
      fin_err   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_any && dec_unmapped) begin
               fin     = 1'b1;
               fin_dbg = grant_dbg;
               fin_err = 1'b1;
            end
         end
         ST_BUSY: begin
            if (mem_rdy) begin
               fin       = 1'b1;
               fin_rdata = (mem_wren == 4'h0) ? mem_rdata : '0;
            end else if (tmo_cnt == TMO_LAST) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state     <= ST_IDLE;
         owner     <= OWN_DBG;
         streak    <= '0;
         tmo_cnt   <= '0;
         mem_en    <= 1'b0;
         mem_adr   <= '0;
         mem_wdata <= '0;
         mem_wren  <= '0;
         mem_sel   <= '0;
         dbg_ack   <= 1'b0;
         dbg_rdata <= '0;
         dbg_err   <= 1'b0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
         cpu_err   <= 1'b0;
      end else begin
         // Responses are single-cycle pulses; the non-owner side stays zero.
         dbg_ack   <= fin && fin_dbg;
         dbg_rdata <= (fin && fin_dbg) ? fin_rdata : '0;
         dbg_err   <= fin && fin_dbg && fin_err;
         cpu_ack   <= fin && !fin_dbg;
         cpu_rdata <= (fin && !fin_dbg) ? fin_rdata : '0;
         cpu_err   <= fin && !fin_dbg && fin_err;

         case (state)
            ST_IDLE: begin
               if (grant_dbg) begin
                  if (streak != STREAK_MAX) streak <= streak + SW'(1);
               end else if (grant_cpu || !dbg_req) begin
                  streak <= '0;
               end
               if (grant_any) begin
                  owner     <= grant_dbg ? OWN_DBG : OWN_CPU;
                  mem_adr   <= gnt_bus.adr[ADR_W-1:0];
                  mem_wdata <= gnt_bus.wdata;
                  mem_wren  <= gnt_bus.wren;
                  tmo_cnt   <= '0;
                  if (dec_unmapped) begin
                     state <= ST_RESP;
                  end else begin
                     state   <= ST_BUSY;
                     mem_en  <= 1'b1;
                     mem_sel <= dec_sel;
                  end
               end
            end
            ST_BUSY: begin
               if (fin) begin
                  state   <= ST_RESP;
                  mem_en  <= 1'b0;
                  mem_sel <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
